// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : Radix-2 iterative multiply/divide unit owning the HI/LO pair.
//            Optional MDU_DIV0_FLAG_EN adds the div_by_zero output.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               div0_q, div0_d;
   logic               done_q, done_d;

   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               last_iter;

   assign rs_neg = ~op[0] & rs_val[WIDTH-1];
   assign rt_neg = ~op[0] & rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? -rs_val : rs_val;
   assign rt_mag = rt_neg ? -rt_val : rt_val;

   // acc holds {partial product, multiplier} for mul, {remainder, quotient} for div
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, m_q} & {(WIDTH+1){acc_q[0]}});
   assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};

   always_comb begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
      if (is_div_q) begin
         if (div_trial[WIDTH]) step = {acc_q[2*WIDTH-2:0], 1'b0};
         else                  step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
   end

   assign prod_fix  = neg_q  ? -step : step;
   assign quo_fix   = neg_q  ? -step[WIDTH-1:0] : step[WIDTH-1:0];
   assign rem_fix   = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
   assign last_iter = (cnt_q == CNT_W'(WIDTH-1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      m_d      = m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d = op[1];
               neg_d    = rs_neg ^ rt_neg;
               rneg_d   = rs_neg;
               div0_d   = op[1] & ~|rt_val;
               cnt_d    = '0;
               state_d  = S_RUN;
               if (op[1]) begin
                  m_d   = rt_mag;
                  acc_d = {{WIDTH{1'b0}}, rs_mag};
               end else begin
                  m_d   = rs_mag;
                  acc_d = {{WIDTH{1'b0}}, rt_mag};
               end
            end else begin
               if (mthi) hi_d = wr_data;
               if (mtlo) lo_d = wr_data;
            end
         end
         S_RUN: begin
            acc_d = step;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else begin
                  // remainder path already reproduces rs_val when divisor is zero
                  hi_d = rem_fix;
                  lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

`ifdef MDU_DIV0_FLAG_EN
   logic dz_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dz_q <= 1'b0;
      else        dz_q <= done_d & div0_q;
   end

   assign div_by_zero = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Scoreboard bench for mdu_hilo (HI/LO mul/div unit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] rs_val = '0;
   logic [W-1:0] rt_val = '0;
   logic         mthi = 1'b0;
   logic         mtlo = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;
`ifdef MDU_DIV0_FLAG_EN
   logic         div_by_zero;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         dz;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   exp_t sb[$];

   mdu_hilo #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
      .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIV0_FLAG_EN
      , .div_by_zero(div_by_zero)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      longint      sa, sbv, q, r;
      logic [63:0] p;
      sa  = longint'(signed'(a));
      sbv = longint'(signed'(b));
      e   = '0;
      case (o)
         2'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
         2'd1: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == '0) begin
               e.dz = 1'b1; e.hi = a; e.lo = '1;
            end else if (o == 2'd2) begin
               q = sa / sbv; r = sa % sbv;
               e.lo = W'(q); e.hi = W'(r);
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // called at posedge+1; returns at E0+1 with start released
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      if (push) sb.push_back(model(o, a, b));
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic await_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_ctl: busy/done=%b required 00", {busy, done}); end
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h required 0", {hi, lo}); end
`ifdef MDU_DIV0_FLAG_EN
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b required 0", div_by_zero); end
`endif
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mthi();
      logic [W-1:0] old_lo;
      int lat;
      exp_t e;
      old_lo = lo;
      mthi = 1'b1; wr_data = 32'h0000_1234;
      @(posedge clk); #1;
      mthi = 1'b0;
      checks++; if (hi !== 32'h1234 || lo !== old_lo) begin errors++; $display("FAIL mthi: hi=%h lo=%h required 00001234 %h", hi, lo, old_lo); end
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hABCD_0001;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      checks++; if (hi !== 32'hABCD_0001 || lo !== 32'hABCD_0001) begin errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h required abcd0001", hi, lo); end
      mthi = 1'b1; wr_data = 32'h5555_5555;
      issue(2'd1, 32'd3, 32'd4, 1'b1);
      mthi = 1'b0;
      checks++; if (hi !== 32'hABCD_0001) begin errors++; $display("FAIL start_beats_mthi: hi=%h required abcd0001", hi); end
      await_done(lat);
      e = sb.pop_front();
      checks++; if (lat !== 32 || {hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL start_beats_mthi_res: lat=%0d hilo=%h required 32 %h", lat, {hi, lo}, {e.hi, e.lo}); end
      @(posedge clk); #1;
   endtask

   task automatic test_mult();
      logic [1:0]   ops [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
      logic [W-1:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h1234_5678, 32'h8000_0000};
      logic [W-1:0] bs  [4] = '{32'hFFFF_FFFF, 32'd7,         32'h9ABC_DEF0, 32'h8000_0000};
      int lat;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i], 1'b1);
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy[%0d]: got %b required 1", i, busy); end
         await_done(lat);
         checks++; if (lat !== 32) begin errors++; $display("FAIL mult_lat[%0d]: got %0d required 32", i, lat); end
         e = sb.pop_front();
         checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL mult_res[%0d]: got %h required %h", i, {hi, lo}, {e.hi, e.lo}); end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_once[%0d]: got %b required 0", i, done); end
      end
   endtask

   task automatic test_div();
      logic [1:0]   ops [5] = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd3};
      logic [W-1:0] as  [5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7,         32'hFFFF_FFFF};
      logic [W-1:0] bs  [5] = '{32'd2,         32'd7,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0010};
      int lat;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], as[i], bs[i], 1'b1);
         await_done(lat);
         checks++; if (lat !== 32) begin errors++; $display("FAIL div_lat[%0d]: got %0d required 32", i, lat); end
         e = sb.pop_front();
         checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL div_res[%0d]: got %h required %h", i, {hi, lo}, {e.hi, e.lo}); end
`ifdef MDU_DIV0_FLAG_EN
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dz[%0d]: got %b required 0", i, div_by_zero); end
`endif
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div0();
      logic [1:0]   ops [2] = '{2'd3, 2'd2};
      logic [W-1:0] as  [2] = '{32'd5, 32'hFFFF_FFF8};
      int lat;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         issue(ops[i], as[i], 32'd0, 1'b1);
         await_done(lat);
         checks++; if (lat !== 32) begin errors++; $display("FAIL div0_lat[%0d]: got %0d required 32", i, lat); end
         e = sb.pop_front();
         checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL div0_res[%0d]: got %h required %h", i, {hi, lo}, {e.hi, e.lo}); end
`ifdef MDU_DIV0_FLAG_EN
         checks++; if (div_by_zero !== e.dz) begin errors++; $display("FAIL div0_flag[%0d]: got %b required %b", i, div_by_zero, e.dz); end
`endif
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL div0_done_once[%0d]: got %b required 0", i, done); end
`ifdef MDU_DIV0_FLAG_EN
         checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div0_flag_clr[%0d]: got %b required 0", i, div_by_zero); end
`endif
      end
   endtask

   task automatic test_in_flight();
      logic [W-1:0] ph, pl;
      int lat;
      exp_t e;
      ph = hi; pl = lo;
      issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op = 2'd3; rs_val = 32'd1000; rt_val = 32'd3;
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      checks++; if (busy !== 1'b1 || hi !== ph || lo !== pl) begin errors++; $display("FAIL inflight_hold: busy=%b hilo=%h required 1 %h", busy, {hi, lo}, {ph, pl}); end
      await_done(lat);
      checks++; if (lat !== 27) begin errors++; $display("FAIL inflight_lat: got %0d required 27", lat); end
      e = sb.pop_front();
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL inflight_res: got %h required %h", {hi, lo}, {e.hi, e.lo}); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat;
      exp_t e;
      issue(2'd1, 32'h0001_0000, 32'h0003_0000, 1'b1);
      repeat (31) @(posedge clk);
      #1;
      start = 1'b1; op = 2'd3; rs_val = 32'd100; rt_val = 32'd7;
      sb.push_back(model(2'd3, 32'd100, 32'd7));
      @(posedge clk); #1;
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_e32: done/busy=%b required 10", {done, busy}); end
      e = sb.pop_front();
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL b2b_first: got %h required %h", {hi, lo}, {e.hi, e.lo}); end
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_e33_accept: busy/done=%b required 10", {busy, done}); end
      await_done(lat);
      checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_lat: got %0d required 32", lat); end
      e = sb.pop_front();
      checks++; if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL b2b_second: got %h required %h", {hi, lo}, {e.hi, e.lo}); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int seen;
      issue(2'd0, 32'h0000_1234, 32'h0000_5678, 1'b0);
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || {hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_mid: busy=%b done=%b hilo=%h required 0 0 0", busy, done, {hi, lo}); end
      #1;
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_nodone: active cycles=%0d required 0", seen); end
   endtask

   initial begin
      test_reset();
      test_mthi();
      test_mult();
      test_div();
      test_div0();
      test_in_flight();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Iterative multiply/divide unit sitting beside the single-cycle ALU.
- Produces the HI/LO register pair that the datapath consumes for mfhi/mflo.
- Operands come from register-file read ports (rs, rt). The unit owns the architectural HI/LO state.
- Radix-2 iteration, 32 cycles per operation. Asserts busy so the core stalls HI/LO readers and any new mul/div.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled only while busy=0.
- op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
- rs_val  input  WIDTH  multiplicand / dividend.
- rt_val  input  WIDTH  multiplier / divisor.
- mthi  input  1  write wr_data to HI.
- mtlo  input  1  write wr_data to LO.
- wr_data  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in flight; core must stall mfhi/mflo/mthi/mtlo/start.
- done  output  1  one-cycle pulse: HI/LO hold a fresh result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- div_by_zero  output  1  present only with MDU_DIV0_FLAG_EN.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal accumulators cleared. This applies mid-operation too: the operation is abandoned and no done pulse follows.
- IDLE state:
  - At an edge with start=1, the unit latches op, the operand magnitudes (absolute values for mult/div; raw for multu/divu) and the result-sign flags. busy goes 1, counter=0, state becomes RUN.
  - start=1 in the same cycle as mthi or mtlo: start wins and the move is dropped.
  - With start=0, mthi writes HI and mtlo writes LO at the edge. Both may be asserted together.
- RUN state:
  - One iteration per edge: shift-add for multiply, restoring shift-subtract for divide. Counter increments.
  - On the 32nd RUN edge (counter=WIDTH-1), the sign-corrected result loads into hi/lo. busy=0, done=1 for exactly the following cycle, and state returns to IDLE.
  - Latency: start sampled at edge E0; hi/lo updated and busy cleared at edge E32; done high E32 to E33.
  - A new start at edge E32 is ignored because busy is sampled high; it is accepted from edge E33.
  - start, mthi and mtlo are ignored while busy=1. hi/lo hold their previous values until E32.
- Results:
  - mult/multu: {hi,lo} = full 2*WIDTH product, signed or unsigned.
  - div/divu: lo = quotient truncated toward zero, hi = remainder. The remainder takes the sign of the dividend.
  - Divide by zero (either signedness): hi = rs_val, lo = all ones. Same 32-cycle latency.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- done is 0 in every cycle other than the single post-completion cycle.

Optional Feature:
- MDU_DIV0_FLAG_EN defined:
  - div_by_zero output exists.
  - It pulses high coincident with done when the completed op was div/divu with rt_val=0; otherwise 0.
  - Reset value 0.
- Not defined: the port and its logic are absent. Divide-by-zero results are unchanged.

Test Plan:
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- mult rs=0xFFFFFFFD(-3) rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then div rs=0xFFFFFFF9(-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu rs=100 rt=7 -> lo=14, hi=2. Then div rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu rs=5 rt=0 -> hi=5, lo=0xFFFFFFFF after 32 cycles. With MDU_DIV0_FLAG_EN, div_by_zero=1 in the done cycle only.
- Operation in flight: assert start (new operands) and mthi at cycle 5 -> both ignored, original result lands at cycle 32. Back-to-back start at E32 ignored, at E33 accepted.
- Idle: mthi wr_data=0x1234 -> hi=0x1234 next edge, lo unchanged. Reset=0 at cycle 10 of a mult -> busy=0, hi=lo=0 immediately, no done afterwards.
